// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM encoding, opcodes, default datapath width.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_MOD = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_div_seq_if.sv
// Start/done handshake and operand/result bus between the opcode decoder and the divider.
interface alu_div_seq_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             dz;

  modport master (output start, A, B, input busy, done, Q, R, dz);
  modport slave  (input start, A, B, output busy, done, Q, R, dz);

endinterface

// File: rtl/alu_div_seq_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, select.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           trial_neg;

  // rem stays below the divisor, so the MSB of the WIDTH+1 bit difference is the borrow
  always_comb begin
    rem_sh    = {rem_i, quo_i[WIDTH-1]};
    trial     = rem_sh - {1'b0, div_i};
    trial_neg = trial[WIDTH];
    rem_o     = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_o     = {quo_i[WIDTH-2:0], ~trial_neg};
  end

endmodule

// File: rtl/alu_div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, start/done handshake.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  alu_div_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; divide-by-zero skips CALC entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = (bus.B == '0) ? ST_FIN : ST_CALC;
      ST_CALC: if (cnt_q == '0) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; results load only on entry to FIN
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    dz_d   = dz_q;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.B != '0) begin
            quo_d = bus.A;
            div_d = bus.B;
            rem_d = '0;
            cnt_d = CNT_W'(WIDTH - 1);
          end else begin
            q_d  = '1;
            r_d  = bus.A;
            dz_d = 1'b1;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          q_d  = step_quo;
          r_d  = step_rem;
          dz_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dz_q   <= dz_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.dz   = dz_q;

endmodule
